// File: rtl/baser_pkg.sv
// Shared BASE-R definitions used by the TX encoder and the scrambler.
// Holds sync headers, block type bytes, MII control characters, the 7-bit
// control codes, the TX state enum and the word class enum. Two helpers
// build the all-control payload and map a terminate lane to its block type.
package baser_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_ERROR = 8'hFE;

    localparam logic [7:0] BT_CTRL  = 8'h1E;
    localparam logic [7:0] BT_START = 8'h78;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_DATA = 1'b1
    } tx_state_t;

    typedef enum logic [2:0] {
        WC_C,
        WC_S,
        WC_D,
        WC_T,
        WC_E
    } word_class_t;

    // 0x1E block carrying the same 7-bit code in all eight lanes.
    function automatic logic [63:0] ctrl_block(input logic [6:0] code);
        return {{8{code}}, BT_CTRL};
    endfunction

    // Block type for a terminate in lane k.
    function automatic logic [7:0] term_type(input logic [2:0] k);
        logic [7:0] t;
        case (k)
            3'd0:    t = 8'h87;
            3'd1:    t = 8'h99;
            3'd2:    t = 8'hAA;
            3'd3:    t = 8'hB4;
            3'd4:    t = 8'hCC;
            3'd5:    t = 8'hD2;
            3'd6:    t = 8'hE1;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/baser_scrambler.sv
// Self-synchronous x^58 + x^39 + 1 scrambler over a 64-bit payload.
// Bit 0 is scrambled first. The state advances only when en is high;
// data_out is always the scrambled image of data_in under the current state.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset, loads SEED
//   en       - advance the state by this payload
//   data_in  - 64-bit unscrambled payload
//   data_out - 64-bit scrambled payload
module baser_scrambler #(
    parameter logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [63:0] data_in,
    output logic [63:0] data_out
);

    logic [57:0] state_q;
    logic [57:0] state_walk;
    logic [63:0] out_walk;
    logic        out_bit;

    // Walk the 64 bits serially; the feedback uses the scrambled output bit.
    always_comb begin
        state_walk = state_q;
        out_walk   = '0;
        out_bit    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            out_bit     = data_in[i] ^ state_walk[38] ^ state_walk[57];
            out_walk[i] = out_bit;
            state_walk  = {state_walk[56:0], out_bit};
        end
    end

    assign data_out = out_walk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else if (en) begin
            state_q <= state_walk;
        end
    end

endmodule

// File: rtl/mii_baser_tx_encoder.sv
// 64b/66b transmit encoder: MII word (64-bit data, 8-bit lane control) in,
// scrambled 66-bit BASE-R block out, two cycles later.
// Stage 1 classifies the word, runs the frame FSM and builds the block;
// stage 2 scrambles the payload (the sync header is never scrambled).
// Handshake: i_valid qualifies i_mii_*; there is no backpressure, every
// valid word is accepted and produces exactly one o_valid block. Without
// i_valid nothing advances and o_block holds its last value.
// Ports:
//   clk         - clock
//   i_rst_n     - asynchronous active-low reset
//   i_mii_data  - lane k = bits [8k+7:8k], lane 0 first on the wire
//   i_mii_ctrl  - bit k marks lane k as a control character
//   i_valid     - input word valid
//   o_block     - [1:0] sync header, [65:2] payload
//   o_valid     - o_block valid
//   o_enc_error - pulses with o_valid when an error block is emitted
//   o_in_frame  - FSM is in DATA (exposes the state register)
module mii_baser_tx_encoder
    import baser_pkg::*;
#(
    parameter bit          SCRAMBLE_EN = 1'b1,
    parameter logic [57:0] SCR_SEED    = 58'h3FF_FFFF_FFFF_FFFF,
    parameter logic [7:0]  IDLE_CODE   = MII_IDLE,
    parameter logic [7:0]  START_CODE  = MII_START,
    parameter logic [7:0]  TERM_CODE   = MII_TERM,
    parameter logic [7:0]  ERROR_CODE  = MII_ERROR
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_mii_data,
    input  logic [7:0]  i_mii_ctrl,
    input  logic        i_valid,
    output logic [65:0] o_block,
    output logic        o_valid,
    output logic        o_enc_error,
    output logic        o_in_frame
);

    localparam logic [7:0] CTRL_ALL = 8'hFF;

    tx_state_t   state_q;
    tx_state_t   state_nxt;
    word_class_t word_class;
    logic [2:0]  term_k;
    logic        all_idle;
    logic        err_char;
    logic        t_ok;
    logic [63:0] term_payload;
    logic [1:0]  enc_sync;
    logic [63:0] enc_payload;
    logic        enc_err;

    logic        s1_valid;
    logic        s1_err;
    logic [1:0]  s1_sync;
    logic [63:0] s1_payload;
    logic [63:0] scr_payload;
    logic [63:0] out_payload;

    // Word classification.
    always_comb begin
        all_idle   = 1'b1;
        err_char   = 1'b0;
        t_ok       = 1'b0;
        word_class = WC_E;
        term_k     = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (i_mii_data[8*k +: 8] != IDLE_CODE) all_idle = 1'b0;
            if (i_mii_ctrl[k] && i_mii_data[8*k +: 8] == ERROR_CODE) err_char = 1'b1;
        end
        if (i_mii_ctrl == CTRL_ALL && all_idle) begin
            word_class = WC_C;
        end else if (i_mii_ctrl == 8'h01 && i_mii_data[7:0] == START_CODE) begin
            word_class = WC_S;
        end else if (i_mii_ctrl == 8'h00) begin
            word_class = WC_D;
        end else begin
            // Tk: control mask FF<<k, terminate in lane k, idles above it.
            for (int k = 0; k < 8; k++) begin
                t_ok = (i_mii_ctrl == (CTRL_ALL << k)) && (i_mii_data[8*k +: 8] == TERM_CODE);
                for (int j = k + 1; j < 8; j++) begin
                    if (i_mii_data[8*j +: 8] != IDLE_CODE) t_ok = 1'b0;
                end
                if (t_ok) begin
                    word_class = WC_T;
                    term_k     = 3'(k);
                end
            end
        end
        if (err_char) word_class = WC_E;
    end

    // Terminate block: data lanes 0..k-1 shift up one byte behind the type.
    always_comb begin
        term_payload       = '0;
        term_payload[7:0]  = term_type(term_k);
        for (int j = 0; j < 7; j++) begin
            if (j < int'(term_k)) term_payload[8*j+8 +: 8] = i_mii_data[8*j +: 8];
        end
    end

    // Frame FSM and block selection. Any word illegal in the current state
    // becomes an error block and drops the FSM back to IDLE.
    always_comb begin
        state_nxt   = state_q;
        enc_sync    = SYNC_CTRL;
        enc_payload = ctrl_block(CC_ERROR);
        enc_err     = 1'b1;
        case (state_q)
            TX_IDLE: begin
                case (word_class)
                    WC_C: begin
                        enc_payload = ctrl_block(CC_IDLE);
                        enc_err     = 1'b0;
                    end
                    WC_S: begin
                        enc_payload = {i_mii_data[63:8], BT_START};
                        enc_err     = 1'b0;
                        state_nxt   = TX_DATA;
                    end
                    default: ;
                endcase
            end
            TX_DATA: begin
                state_nxt = TX_IDLE;
                case (word_class)
                    WC_D: begin
                        enc_sync    = SYNC_DATA;
                        enc_payload = i_mii_data;
                        enc_err     = 1'b0;
                        state_nxt   = TX_DATA;
                    end
                    WC_T: begin
                        enc_payload = term_payload;
                        enc_err     = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= TX_IDLE;
        end else if (i_valid) begin
            state_q <= state_nxt;
        end
    end

    assign o_in_frame = (state_q == TX_DATA);

    // Stage 1 register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid   <= 1'b0;
            s1_err     <= 1'b0;
            s1_sync    <= '0;
            s1_payload <= '0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_err     <= enc_err;
                s1_sync    <= enc_sync;
                s1_payload <= enc_payload;
            end
        end
    end

    baser_scrambler #(
        .SEED(SCR_SEED)
    ) u_scrambler (
        .clk     (clk),
        .rst_n   (i_rst_n),
        .en      (s1_valid & SCRAMBLE_EN),
        .data_in (s1_payload),
        .data_out(scr_payload)
    );

    assign out_payload = SCRAMBLE_EN ? scr_payload : s1_payload;

    // Stage 2 register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_block     <= '0;
            o_valid     <= 1'b0;
            o_enc_error <= 1'b0;
        end else begin
            o_valid     <= s1_valid;
            o_enc_error <= s1_valid & s1_err;
            if (s1_valid) o_block <= {out_payload, s1_sync};
        end
    end

endmodule

// File: tb/tb_mii_baser_tx_encoder.sv
// Bench for mii_baser_tx_encoder. Two instances share one stimulus stream:
// u_dut_plain (scrambling bypassed) and u_dut_scr (scrambling on). A
// word-level model derives the expected block, error flag and frame state
// from the block encoding rules; a bench descrambler recovers the scrambled
// payload. Directed words carry hand-computed literal blocks in exp_q.
module tb_mii_baser_tx_encoder;

    localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [1:0]  HC = 2'b10;
    localparam logic [1:0]  HD = 2'b01;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] mii_data = '0;
    logic [7:0]  mii_ctrl = '0;
    logic        mii_valid = 1'b0;

    always #5 clk = ~clk;

    logic [65:0] blk_p, blk_s;
    logic        v_p, v_s, e_p, e_s, f_p, f_s;

    mii_baser_tx_encoder #(.SCRAMBLE_EN(1'b0)) u_dut_plain (
        .clk(clk), .i_rst_n(rst_n), .i_mii_data(mii_data), .i_mii_ctrl(mii_ctrl),
        .i_valid(mii_valid), .o_block(blk_p), .o_valid(v_p), .o_enc_error(e_p),
        .o_in_frame(f_p)
    );

    mii_baser_tx_encoder #(.SCRAMBLE_EN(1'b1), .SCR_SEED(SEED)) u_dut_scr (
        .clk(clk), .i_rst_n(rst_n), .i_mii_data(mii_data), .i_mii_ctrl(mii_ctrl),
        .i_valid(mii_valid), .o_block(blk_s), .o_valid(v_s), .o_enc_error(e_s),
        .o_in_frame(f_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic        v;
        logic        err;
        logic [1:0]  hdr;
        logic [63:0] pay;
    } exp_t;

    logic [7:0] ttype [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    exp_t pipe0, pipe1;
    logic m_in_frame;
    logic nf;

    task automatic model_word(input logic [63:0] d, input logic [7:0] c, input logic fr,
                              output exp_t e, output logic nfr);
        logic [7:0]  b [8];
        logic        kc, ks, kd, kt;
        int          t;
        logic [63:0] errp, tp;
        for (int j = 0; j < 8; j++) b[j] = d[8*j +: 8];
        kc = (c == 8'hFF);
        for (int j = 0; j < 8; j++) if (b[j] != 8'h07) kc = 1'b0;
        ks = (c == 8'h01) && (b[0] == 8'hFB);
        kd = (c == 8'h00);
        t = 8;
        for (int j = 7; j >= 0; j--) if (c[j]) t = j;
        kt = (t < 8);
        for (int j = 0; j < 8; j++) if ((j >= t) != c[j]) kt = 1'b0;
        if (kt) begin
            if (b[t] != 8'hFD) kt = 1'b0;
            for (int j = t + 1; j < 8; j++) if (b[j] != 8'h07) kt = 1'b0;
        end
        errp = 64'h1E;
        for (int j = 0; j < 8; j++) errp[8 + 7*j +: 7] = 7'h1E;
        tp = '0;
        if (kt) begin
            tp[7:0] = ttype[t];
            for (int j = 0; j < t; j++) tp[8*(j+1) +: 8] = b[j];
        end
        e.v = 1'b1; e.err = 1'b1; e.hdr = HC; e.pay = errp; nfr = 1'b0;
        if (!fr) begin
            if (kc) begin
                e.err = 1'b0; e.pay = 64'h1E;
            end else if (ks) begin
                e.err = 1'b0; e.pay = {d[63:8], 8'h78}; nfr = 1'b1;
            end
        end else begin
            if (kd) begin
                e.err = 1'b0; e.hdr = HD; e.pay = d; nfr = 1'b1;
            end else if (kt) begin
                e.err = 1'b0; e.pay = tp;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe0 = '0;
            pipe1 = '0;
            m_in_frame = 1'b0;
        end else begin
            pipe1 = pipe0;
            if (mii_valid) begin
                model_word(mii_data, mii_ctrl, m_in_frame, pipe0, nf);
                m_in_frame = nf;
            end else begin
                pipe0 = '0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    // exp_q entry: {has_literal, literal_err, literal_block}, one per valid word.
    logic [67:0] exp_q[$];
    logic [67:0] pin;
    logic [65:0] exp_blk_p;
    logic [57:0] dsc;
    logic [63:0] rec;
    logic        in_bit;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_blk_p = '0;
            dsc = SEED;
            exp_q.delete();
            check("rst_block_plain", blk_p, '0);
            check("rst_block_scr", blk_s, '0);
            check("rst_valid", {v_p, v_s}, '0);
            check("rst_enc_error", {e_p, e_s}, '0);
            check("rst_in_frame", {f_p, f_s}, '0);
        end else begin
            if (pipe1.v) exp_blk_p = {pipe1.pay, pipe1.hdr};
            check("valid_plain", v_p, pipe1.v);
            check("valid_scr", v_s, pipe1.v);
            check("enc_error_plain", e_p, pipe1.v & pipe1.err);
            check("enc_error_scr", e_s, pipe1.v & pipe1.err);
            check("in_frame_plain", f_p, m_in_frame);
            check("in_frame_scr", f_s, m_in_frame);
            check("block_plain", blk_p, exp_blk_p);
            if (pipe1.v) begin
                rec = '0;
                for (int i = 0; i < 64; i++) begin
                    in_bit = blk_s[2 + i];
                    rec[i] = in_bit ^ dsc[38] ^ dsc[57];
                    dsc = {dsc[56:0], in_bit};
                end
                check("descrambled_payload", rec, pipe1.pay);
                check("header_scr", blk_s[1:0], pipe1.hdr);
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 66'(exp_q.size()), 66'd1);
                end else begin
                    pin = exp_q.pop_front();
                    if (pin[67]) begin
                        check("literal_block", blk_p, pin[65:0]);
                        check("literal_enc_error", e_p, pin[66]);
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic [63:0] d, input logic [7:0] c,
                         input logic has, input logic err, input logic [65:0] blk);
        @(posedge clk);
        #1;
        mii_data = d;
        mii_ctrl = c;
        mii_valid = 1'b1;
        exp_q.push_back({has, err, blk});
    endtask

    task automatic word(input logic [63:0] d, input logic [7:0] c);
        drive(d, c, 1'b0, 1'b0, '0);
    endtask

    task automatic bubble(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            mii_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        mii_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_word();
        word(64'h0707070707070707, 8'hFF);
    endtask

    // Preamble start, len payload bytes, terminate; reset_at >= 0 aborts the
    // frame with a reset before that data word.
    task automatic send_frame(input int len, input int reset_at);
        logic [63:0] d;
        logic [7:0]  c;
        int          r;
        word(64'hD5555555555555FB, 8'h01);
        for (int w = 0; w < len / 8; w++) begin
            if (w == reset_at) begin
                do_reset();
                return;
            end
            if ($urandom_range(0, 4) == 0) bubble(1);
            for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'($urandom_range(0, 255));
            word(d, 8'h00);
        end
        r = len % 8;
        d = '0;
        c = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < r) begin
                d[8*j +: 8] = 8'($urandom_range(0, 255));
            end else begin
                d[8*j +: 8] = (j == r) ? 8'hFD : 8'h07;
                c[j] = 1'b1;
            end
        end
        word(d, c);
    endtask

    localparam logic [63:0] ERR_PAY = 64'h3C78_F1E3_C78F_1E1E;

    int lens [9] = '{8, 64, 1500, 9, 10, 11, 13, 14, 15};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed words with literal blocks.
        drive(64'h0707070707070707, 8'hFF, 1'b1, 1'b0, {64'h1E, HC});
        drive(64'hD5555555555555FB, 8'h01, 1'b1, 1'b0, {64'hD555555555555578, HC});
        drive(64'h0123456789ABCDEF, 8'h00, 1'b1, 1'b0, {64'h0123456789ABCDEF, HD});
        drive(64'h07070707070707FD, 8'hFF, 1'b1, 1'b0, {64'h87, HC});
        drive(64'h0707070707070707, 8'hFF, 1'b1, 1'b0, {64'h1E, HC});
        drive(64'hD5555555555555FB, 8'h01, 1'b1, 1'b0, {64'hD555555555555578, HC});
        drive(64'hFEDCBA9876543210, 8'h00, 1'b1, 1'b0, {64'hFEDCBA9876543210, HD});
        bubble(2);
        drive(64'h070707FD44332211, 8'hF0, 1'b1, 1'b0, {64'h44332211CC, HC});
        drive(64'h0707070707070707, 8'hFF, 1'b1, 1'b0, {64'h1E, HC});
        // D while idle.
        drive(64'h1122334455667788, 8'h00, 1'b1, 1'b1, {ERR_PAY, HC});
        drive(64'h0707070707070707, 8'hFF, 1'b1, 1'b0, {64'h1E, HC});
        // S inside a frame, then the orphaned D.
        drive(64'hD5555555555555FB, 8'h01, 1'b1, 1'b0, {64'hD555555555555578, HC});
        drive(64'h0000000000000000, 8'h00, 1'b1, 1'b0, {64'h0, HD});
        drive(64'hD5555555555555FB, 8'h01, 1'b1, 1'b1, {ERR_PAY, HC});
        drive(64'hAAAAAAAAAAAAAAAA, 8'h00, 1'b1, 1'b1, {ERR_PAY, HC});
        drive(64'h0707070707070707, 8'hFF, 1'b1, 1'b0, {64'h1E, HC});
        // ERROR_CODE lane inside a frame.
        drive(64'hD5555555555555FB, 8'h01, 1'b1, 1'b0, {64'hD555555555555578, HC});
        drive(64'h07070707070707FE, 8'hFF, 1'b1, 1'b1, {ERR_PAY, HC});
        drive(64'h0707070707070707, 8'hFF, 1'b1, 1'b0, {64'h1E, HC});
        bubble(2);

        // Frames with scrambling and valid gaps.
        foreach (lens[i]) begin
            idle_word();
            idle_word();
            send_frame(lens[i], -1);
            repeat ($urandom_range(1, 3)) idle_word();
            if ($urandom_range(0, 1) == 1) bubble(1);
        end

        // Reset in the middle of a long frame, then clean frames.
        idle_word();
        send_frame(1500, 100);
        idle_word();
        send_frame(64, -1);
        idle_word();
        send_frame(1500, -1);
        idle_word();
        bubble(6);

        check("exp_q_drained", 66'(exp_q.size()), 66'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
